// File: rtl/sc_spawner_pkg.sv
// Shared definitions for the obstacle spawner: FSM encodings, gap table and lane helpers.
package sc_spawner_pkg;

  localparam int unsigned ROW_WIDTH_DEF = 8;
  localparam int unsigned GAP_W_DEF     = 3;
  localparam int unsigned LANE_W        = 3;
  localparam int unsigned LANE_COUNT    = 8;
  localparam int unsigned LEVEL_W       = 2;
  localparam int unsigned STATE_W       = 2;
  localparam int unsigned GAP_TBL_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_SPAWN   = 2'b10,
    ST_ADVANCE = 2'b11
  } spawnState_t;

  // Scroll ticks between obstacles for each difficulty level.
  localparam logic [GAP_TBL_W-1:0] GAP_LEVEL0 = 3'd4;
  localparam logic [GAP_TBL_W-1:0] GAP_LEVEL1 = 3'd3;
  localparam logic [GAP_TBL_W-1:0] GAP_LEVEL2 = 3'd2;
  localparam logic [GAP_TBL_W-1:0] GAP_LEVEL3 = 3'd1;

  function automatic logic [GAP_TBL_W-1:0] gapForLevel(input logic [LEVEL_W-1:0] level);
    logic [GAP_TBL_W-1:0] gap;
    case (level)
      2'd0:    gap = GAP_LEVEL0;
      2'd1:    gap = GAP_LEVEL1;
      2'd2:    gap = GAP_LEVEL2;
      default: gap = GAP_LEVEL3;
    endcase
    return gap;
  endfunction

  // Never repeat the previous lane: bump by one, wrapping 7 -> 0.
  function automatic logic [LANE_W-1:0] pickLane(input logic [LANE_W-1:0] rnd,
                                                 input logic [LANE_W-1:0] last);
    logic [LANE_W-1:0] lane;
    lane = (rnd == last) ? LANE_W'(rnd + LANE_W'(1)) : rnd;
    return lane;
  endfunction

  function automatic logic [LANE_COUNT-1:0] laneOneHot(input logic [LANE_W-1:0] lane);
    logic [LANE_COUNT-1:0] oneHot;
    oneHot = LANE_COUNT'(1) << lane;
    return oneHot;
  endfunction

endpackage

// File: rtl/sc_gap_counter.sv
// Scroll-tick gap counter: load has priority over decrement, otherwise holds.
module sc_gap_counter
  import sc_spawner_pkg::*;
#(
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             SC_GapCOUNTER_CLOCK_50,
  input  logic             SC_RegSHIFTER_RESET_InHigh,
  input  logic             SC_GapCOUNTER_load_InHigh,
  input  logic [GAP_W-1:0] SC_GapCOUNTER_loadValue_InBUS,
  input  logic             SC_GapCOUNTER_decrement_InHigh,
  output logic [GAP_W-1:0] SC_GapCOUNTER_count_OutBUS
);

  logic [GAP_W-1:0] gapCount;

  // Decrement saturates at zero so a stray request cannot wrap the gap.
  always_ff @(posedge SC_GapCOUNTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      gapCount <= '0;
    end else if (SC_GapCOUNTER_load_InHigh) begin
      gapCount <= SC_GapCOUNTER_loadValue_InBUS;
    end else if (SC_GapCOUNTER_decrement_InHigh && (gapCount != '0)) begin
      gapCount <= gapCount - GAP_W'(1);
    end
  end

  assign SC_GapCOUNTER_count_OutBUS = gapCount;

endmodule

// File: rtl/sc_obstacle_spawner.sv
// Obstacle spawner: emits one road row per scroll tick, with an obstacle every GAP[level] ticks.
module sc_obstacle_spawner
  import sc_spawner_pkg::*;
#(
  parameter int unsigned ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int unsigned GAP_W     = GAP_W_DEF
) (
  input  logic                 SC_ObstacleSPAWNER_CLOCK_50,
  input  logic                 SC_RegSHIFTER_RESET_InHigh,
  input  logic                 SC_ObstacleSPAWNER_enable_InHigh,
  input  logic                 SC_ObstacleSPAWNER_scrollTick_InHigh,
  input  logic [LANE_W-1:0]    SC_ObstacleSPAWNER_random_InBUS,
  input  logic [LEVEL_W-1:0]   SC_ObstacleSPAWNER_level_InBUS,
  output logic [ROW_WIDTH-1:0] SC_ObstacleSPAWNER_row_OutBUS,
  output logic                 SC_ObstacleSPAWNER_rowValid_OutHigh,
  output logic                 SC_ObstacleSPAWNER_rndAdvance_OutHigh,
  output logic                 SC_ObstacleSPAWNER_overrun_OutHigh,
  output logic [STATE_W-1:0]   SC_ObstacleSPAWNER_state_OutBUS
);

  spawnState_t           state;
  logic [LANE_W-1:0]     lastLane;
  logic [LANE_W-1:0]     pendingLane;
  logic [LANE_W-1:0]     laneSel;
  logic [ROW_WIDTH-1:0]  rowReg;
  logic                  rowValidReg;
  logic                  rndAdvanceReg;
  logic                  overrunReg;

  logic [GAP_W-1:0]      gapCount;
  logic [GAP_W-1:0]      gapReloadValue;
  logic                  gapLoad;
  logic                  gapDecrement;
  logic                  gapMoreThanOne;

  assign laneSel        = pickLane(SC_ObstacleSPAWNER_random_InBUS, lastLane);
  assign gapReloadValue = GAP_W'(gapForLevel(SC_ObstacleSPAWNER_level_InBUS));
  assign gapMoreThanOne = (gapCount > GAP_W'(1));

  // Gap is reloaded on leaving IDLE and in SPAWN, so level changes land only at a reload.
  always_comb begin
    gapLoad      = 1'b0;
    gapDecrement = 1'b0;
    if ((state == ST_IDLE) && SC_ObstacleSPAWNER_enable_InHigh) begin
      gapLoad = 1'b1;
    end else if (state == ST_SPAWN) begin
      gapLoad = 1'b1;
    end else if ((state == ST_COUNT) && SC_ObstacleSPAWNER_enable_InHigh &&
                 SC_ObstacleSPAWNER_scrollTick_InHigh && gapMoreThanOne) begin
      gapDecrement = 1'b1;
    end
  end

  sc_gap_counter #(
    .GAP_W(GAP_W)
  ) uGapCounter (
    .SC_GapCOUNTER_CLOCK_50         (SC_ObstacleSPAWNER_CLOCK_50),
    .SC_RegSHIFTER_RESET_InHigh     (SC_RegSHIFTER_RESET_InHigh),
    .SC_GapCOUNTER_load_InHigh      (gapLoad),
    .SC_GapCOUNTER_loadValue_InBUS  (gapReloadValue),
    .SC_GapCOUNTER_decrement_InHigh (gapDecrement),
    .SC_GapCOUNTER_count_OutBUS     (gapCount)
  );

  // FSM and registered outputs; row and strobes default low every cycle.
  always_ff @(posedge SC_ObstacleSPAWNER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      state         <= ST_IDLE;
      lastLane      <= '0;
      pendingLane   <= '0;
      rowReg        <= '0;
      rowValidReg   <= 1'b0;
      rndAdvanceReg <= 1'b0;
      overrunReg    <= 1'b0;
    end else begin
      rowReg        <= '0;
      rowValidReg   <= 1'b0;
      rndAdvanceReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (SC_ObstacleSPAWNER_enable_InHigh) begin
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!SC_ObstacleSPAWNER_enable_InHigh) begin
            state <= ST_IDLE;
          end else if (SC_ObstacleSPAWNER_scrollTick_InHigh) begin
            rowValidReg <= 1'b1;
            if (!gapMoreThanOne) begin
              rowReg      <= ROW_WIDTH'(laneOneHot(laneSel));
              pendingLane <= laneSel;
              state       <= ST_SPAWN;
            end
          end
        end
        ST_SPAWN: begin
          lastLane      <= pendingLane;
          rndAdvanceReg <= 1'b1;
          state         <= ST_ADVANCE;
          if (SC_ObstacleSPAWNER_scrollTick_InHigh) begin
            overrunReg <= 1'b1;
          end
        end
        ST_ADVANCE: begin
          state <= SC_ObstacleSPAWNER_enable_InHigh ? ST_COUNT : ST_IDLE;
          if (SC_ObstacleSPAWNER_scrollTick_InHigh) begin
            overrunReg <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign SC_ObstacleSPAWNER_row_OutBUS         = rowReg;
  assign SC_ObstacleSPAWNER_rowValid_OutHigh   = rowValidReg;
  assign SC_ObstacleSPAWNER_rndAdvance_OutHigh = rndAdvanceReg;
  assign SC_ObstacleSPAWNER_overrun_OutHigh    = overrunReg;
  assign SC_ObstacleSPAWNER_state_OutBUS       = state;

endmodule

// File: tb/tb_sc_obstacle_spawner.sv
// Directed self-checking bench for sc_obstacle_spawner.
module tb_sc_obstacle_spawner;

  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          tick;
  logic [2:0]    rnd;
  logic [1:0]    lvl;
  logic [RW-1:0] row;
  logic          rowValid;
  logic          rndAdv;
  logic          overrun;
  logic [1:0]    st;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0]    LANE_RND [5] = '{3'd5, 3'd5, 3'd7, 3'd7, 3'd0};
  localparam logic [RW-1:0] LANE_ROW [5] = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

  always #5 clk = ~clk;

  sc_obstacle_spawner #(
    .ROW_WIDTH(RW),
    .GAP_W    (3)
  ) dut (
    .SC_ObstacleSPAWNER_CLOCK_50          (clk),
    .SC_RegSHIFTER_RESET_InHigh           (rst),
    .SC_ObstacleSPAWNER_enable_InHigh     (en),
    .SC_ObstacleSPAWNER_scrollTick_InHigh (tick),
    .SC_ObstacleSPAWNER_random_InBUS      (rnd),
    .SC_ObstacleSPAWNER_level_InBUS       (lvl),
    .SC_ObstacleSPAWNER_row_OutBUS        (row),
    .SC_ObstacleSPAWNER_rowValid_OutHigh  (rowValid),
    .SC_ObstacleSPAWNER_rndAdvance_OutHigh(rndAdv),
    .SC_ObstacleSPAWNER_overrun_OutHigh   (overrun),
    .SC_ObstacleSPAWNER_state_OutBUS      (st)
  );

  task automatic step(input logic tk);
    tick = tk;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic doReset();
    rst  = 1'b1;
    en   = 1'b0;
    tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rnd = 3'd0;
    lvl = 2'd0;
    doReset();
    checks++;
    if ({st, row, rowValid, rndAdv, overrun} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got st=%b row=%h rv=%b adv=%b ovr=%b want all zero",
               st, row, rowValid, rndAdv, overrun);
    end
  endtask

  task automatic test_basic_spawn();
    logic [RW-1:0] expRow;
    doReset();
    lvl = 2'd0;
    rnd = 3'd1;
    en  = 1'b1;
    step(1'b0);
    checks++;
    if (st !== 2'b01) begin
      errors++;
      $display("FAIL basic_enter_count got st=%b want 01", st);
    end
    for (int i = 1; i <= 4; i++) begin
      expRow = (i == 4) ? 8'h02 : 8'h00;
      step(1'b1);
      checks++;
      if (rowValid !== 1'b1 || row !== expRow) begin
        errors++;
        $display("FAIL basic_row%0d got rv=%b row=%h want rv=1 row=%h", i, rowValid, row, expRow);
      end
      if (i < 4) begin
        step(1'b0);
        checks++;
        if (rowValid !== 1'b0 || row !== 8'h00 || st !== 2'b01) begin
          errors++;
          $display("FAIL basic_gap%0d got rv=%b row=%h st=%b want rv=0 row=00 st=01",
                   i, rowValid, row, st);
        end
      end
    end
    checks++;
    if (st !== 2'b10 || rndAdv !== 1'b0) begin
      errors++;
      $display("FAIL basic_spawn_state got st=%b adv=%b want st=10 adv=0", st, rndAdv);
    end
    step(1'b0);
    checks++;
    if (rndAdv !== 1'b1 || rowValid !== 1'b0 || row !== 8'h00 || st !== 2'b11) begin
      errors++;
      $display("FAIL basic_advance got adv=%b rv=%b row=%h st=%b want adv=1 rv=0 row=00 st=11",
               rndAdv, rowValid, row, st);
    end
    step(1'b0);
    checks++;
    if (rndAdv !== 1'b0 || st !== 2'b01) begin
      errors++;
      $display("FAIL basic_back_to_count got adv=%b st=%b want adv=0 st=01", rndAdv, st);
    end
  endtask

  task automatic test_lane_select();
    doReset();
    lvl = 2'd3;
    en  = 1'b1;
    step(1'b0);
    for (int i = 0; i < 5; i++) begin
      rnd = LANE_RND[i];
      step(1'b1);
      checks++;
      if (rowValid !== 1'b1 || row !== LANE_ROW[i]) begin
        errors++;
        $display("FAIL lane_row%0d rnd=%0d got rv=%b row=%h want rv=1 row=%h",
                 i, LANE_RND[i], rowValid, row, LANE_ROW[i]);
      end
      step(1'b0);
      step(1'b0);
    end
  endtask

  task automatic test_overrun();
    int rvCount;
    doReset();
    lvl = 2'd3;
    rnd = 3'd3;
    en  = 1'b1;
    step(1'b0);
    rvCount = 0;
    step(1'b1);
    rvCount += int'(rowValid);
    step(1'b1);
    rvCount += int'(rowValid);
    checks++;
    if (overrun !== 1'b1 || rndAdv !== 1'b1) begin
      errors++;
      $display("FAIL overrun_in_spawn got ovr=%b adv=%b want ovr=1 adv=1", overrun, rndAdv);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      rvCount += int'(rowValid);
    end
    checks++;
    if (rvCount !== 1 || overrun !== 1'b1 || st !== 2'b01) begin
      errors++;
      $display("FAIL overrun_single_row got rows=%0d ovr=%b st=%b want rows=1 ovr=1 st=01",
               rvCount, overrun, st);
    end
    doReset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got ovr=%b want 0", overrun);
    end
    en = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    checks++;
    if (overrun !== 1'b1 || rowValid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_in_advance got ovr=%b rv=%b want ovr=1 rv=0", overrun, rowValid);
    end
  endtask

  task automatic test_idle_tick();
    doReset();
    step(1'b1);
    step(1'b1);
    checks++;
    if (overrun !== 1'b0 || st !== 2'b00 || rowValid !== 1'b0) begin
      errors++;
      $display("FAIL idle_tick got ovr=%b st=%b rv=%b want ovr=0 st=00 rv=0", overrun, st, rowValid);
    end
  endtask

  task automatic test_reset_mid_spawn();
    int advCount;
    doReset();
    lvl = 2'd3;
    rnd = 3'd4;
    en  = 1'b1;
    step(1'b0);
    step(1'b1);
    checks++;
    if (rowValid !== 1'b1 || row !== 8'h10 || st !== 2'b10) begin
      errors++;
      $display("FAIL abort_pre got rv=%b row=%h st=%b want rv=1 row=10 st=10", rowValid, row, st);
    end
    en  = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({st, row, rowValid, rndAdv, overrun} !== 13'd0) begin
      errors++;
      $display("FAIL abort_async got st=%b row=%h rv=%b adv=%b ovr=%b want all zero",
               st, row, rowValid, rndAdv, overrun);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    advCount = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      advCount += int'(rndAdv) + int'(rowValid);
    end
    checks++;
    if (advCount !== 0 || st !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_pulse got pulses=%0d st=%b want pulses=0 st=00", advCount, st);
    end
    en = 1'b1;
    step(1'b0);
    checks++;
    if (st !== 2'b01) begin
      errors++;
      $display("FAIL abort_reenable got st=%b want 01", st);
    end
  endtask

  task automatic test_enable_drop();
    int rvCount;
    doReset();
    lvl = 2'd2;
    rnd = 3'd6;
    en  = 1'b1;
    step(1'b0);
    en = 1'b0;
    step(1'b0);
    rvCount = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      rvCount += int'(rowValid);
    end
    checks++;
    if (rvCount !== 0 || st !== 2'b00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL disable_rows got rows=%0d st=%b ovr=%b want rows=0 st=00 ovr=0",
               rvCount, st, overrun);
    end
    en = 1'b1;
    step(1'b0);
    step(1'b1);
    checks++;
    if (rowValid !== 1'b1 || row !== 8'h00 || st !== 2'b01) begin
      errors++;
      $display("FAIL reenable_first got rv=%b row=%h st=%b want rv=1 row=00 st=01", rowValid, row, st);
    end
    step(1'b1);
    checks++;
    if (rowValid !== 1'b1 || row !== 8'h40 || st !== 2'b10) begin
      errors++;
      $display("FAIL reenable_spawn got rv=%b row=%h st=%b want rv=1 row=40 st=10", rowValid, row, st);
    end
  endtask

  task automatic test_level_change();
    doReset();
    lvl = 2'd0;
    rnd = 3'd2;
    en  = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    lvl = 2'd3;
    step(1'b1);
    checks++;
    if (rowValid !== 1'b1 || row !== 8'h00 || st !== 2'b01) begin
      errors++;
      $display("FAIL level_third_tick got rv=%b row=%h st=%b want rv=1 row=00 st=01", rowValid, row, st);
    end
    step(1'b1);
    checks++;
    if (row !== 8'h04 || st !== 2'b10) begin
      errors++;
      $display("FAIL level_old_gap got row=%h st=%b want row=04 st=10", row, st);
    end
    step(1'b0);
    step(1'b0);
    step(1'b1);
    checks++;
    if (rowValid !== 1'b1 || row !== 8'h08 || st !== 2'b10) begin
      errors++;
      $display("FAIL level_new_gap got rv=%b row=%h st=%b want rv=1 row=08 st=10", rowValid, row, st);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    tick = 1'b0;
    rnd  = 3'd0;
    lvl  = 2'd0;
    test_reset();
    test_basic_spawn();
    test_lane_select();
    test_overrun();
    test_idle_tick();
    test_reset_mid_spawn();
    test_enable_drop();
    test_level_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
